// File: rtl/rs232_mem_pkg.sv
// Shared constants for the RS-232 memory command controller.
// Holds state encodings, default command/response bytes and frame constants.
package rs232_mem_pkg;

    localparam int ADDR_W = 14;
    localparam int ADDR_HI_BITS = ADDR_W - 8;

    localparam logic [7:0]  DEF_CMD_WR  = 8'h57;
    localparam logic [7:0]  DEF_CMD_RD  = 8'h52;
    localparam logic [7:0]  DEF_ACK     = 8'h4B;
    localparam logic [7:0]  DEF_NAK     = 8'h3F;
    localparam logic [15:0] DEF_TIMEOUT = 16'd50000;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ADDR_H  = 4'd1;
    localparam logic [3:0] ST_ADDR_L  = 4'd2;
    localparam logic [3:0] ST_DATA    = 4'd3;
    localparam logic [3:0] ST_MEM_WR  = 4'd4;
    localparam logic [3:0] ST_MEM_RD  = 4'd5;
    localparam logic [3:0] ST_RD_CAP  = 4'd6;
    localparam logic [3:0] ST_TX_REQ  = 4'd7;
    localparam logic [3:0] ST_TX_WAIT = 4'd8;

    // States that are mid-frame and waiting on the next received byte.
    function automatic logic is_rx_wait(input logic [3:0] st);
        return (st == ST_ADDR_H) || (st == ST_ADDR_L) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/rs232_mem_timeout.sv
// Inter-byte timer: counts enabled cycles since the last clear and
// flags expiry once the count reaches LIMIT.
module rs232_mem_timeout #(
    parameter logic [15:0] LIMIT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_reg;

    assign expired = (count_reg >= LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 16'd0;
        end else if (clear) begin
            count_reg <= 16'd0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: rtl/rs232_mem_ctrl.sv
// Byte-oriented memory access controller driven by a UART: decodes
// write/read frames, drives an external synchronous RAM and sends a reply byte.
module rs232_mem_ctrl
    import rs232_mem_pkg::*;
#(
    parameter logic [7:0]  CMD_WR  = DEF_CMD_WR,
    parameter logic [7:0]  CMD_RD  = DEF_CMD_RD,
    parameter logic [7:0]  ACK     = DEF_ACK,
    parameter logic [7:0]  NAK     = DEF_NAK,
    parameter logic [15:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              rx_overrun
);

    logic [3:0]        state_reg, state_next;
    logic              op_wr_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;
    logic [7:0]        tx_data_reg;
    logic              wait_state;
    logic              rx_accept;
    logic              is_cmd;
    logic              addr_h_bad;
    logic              timer_expired;

    assign wait_state = is_rx_wait(state_reg);
    assign rx_accept  = rx_valid && ((state_reg == ST_IDLE) || wait_state);
    assign is_cmd     = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign addr_h_bad = (rx_data[7:ADDR_HI_BITS] != '0);

    // Timer only runs while a frame is half received; idle/response time is not counted.
    rs232_mem_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_accept || !wait_state),
        .enable  (wait_state),
        .expired (timer_expired)
    );

    assign tx_data    = tx_data_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_write  = (state_reg == ST_MEM_WR);
    assign tx_start   = (state_reg == ST_TX_REQ) && !tx_busy;
    assign busy       = (state_reg != ST_IDLE);
    assign rx_overrun = rx_valid && !rx_accept;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (rx_valid) state_next = is_cmd ? ST_ADDR_H : ST_TX_REQ;
            ST_ADDR_H: begin
                if (rx_valid)           state_next = addr_h_bad ? ST_TX_REQ : ST_ADDR_L;
                else if (timer_expired) state_next = ST_IDLE;
            end
            ST_ADDR_L: begin
                if (rx_valid)           state_next = op_wr_reg ? ST_DATA : ST_MEM_RD;
                else if (timer_expired) state_next = ST_IDLE;
            end
            ST_DATA: begin
                if (rx_valid)           state_next = ST_MEM_WR;
                else if (timer_expired) state_next = ST_IDLE;
            end
            ST_MEM_WR:  state_next = ST_TX_REQ;
            ST_MEM_RD:  state_next = ST_RD_CAP;
            ST_RD_CAP:  state_next = ST_TX_REQ;
            ST_TX_REQ:  if (!tx_busy) state_next = ST_TX_WAIT;
            ST_TX_WAIT: if (!tx_busy) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_wr_reg     <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 8'h00;
            tx_data_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (rx_valid) begin
                    if (is_cmd) op_wr_reg   <= (rx_data == CMD_WR);
                    else        tx_data_reg <= NAK;
                end
                ST_ADDR_H: if (rx_valid) begin
                    if (addr_h_bad) tx_data_reg <= NAK;
                    else            mem_addr_reg[ADDR_W-1:8] <= rx_data[ADDR_HI_BITS-1:0];
                end
                ST_ADDR_L: if (rx_valid) mem_addr_reg[7:0] <= rx_data;
                ST_DATA:   if (rx_valid) mem_wdata_reg <= rx_data;
                ST_MEM_WR: tx_data_reg <= ACK;
                // RAM has one cycle of read latency; MEM_RD exists to cover it.
                ST_RD_CAP: tx_data_reg <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rs232_mem_ctrl.md
RS232_MEM_CTRL -- requirements
Module: rs232_mem_ctrl

Interface
REQ-001 SHALL have parameter CMD_WR, default 8'h57 ('W'), write command byte.
REQ-002 SHALL have parameter CMD_RD, default 8'h52 ('R'), read command byte.
REQ-003 SHALL have parameter ACK, default 8'h4B ('K'), write-complete response byte.
REQ-004 SHALL have parameter NAK, default 8'h3F ('?'), error response byte.
REQ-005 SHALL have parameter TIMEOUT, default 16'd50000, inter-byte timeout in clk cycles.
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rx_data  in  8  received UART byte, valid when rx_valid=1.
REQ-009 SHALL have port rx_valid  in  1  one-cycle strobe, new byte received.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port tx_data  out  8  byte to transmit.
REQ-012 SHALL have port tx_start  out  1  one-cycle transmit request.
REQ-013 SHALL have port mem_addr  out  14  memory address.
REQ-014 SHALL have port mem_write  out  1  memory write enable.
REQ-015 SHALL have port mem_wdata  out  8  memory write data.
REQ-016 SHALL have port mem_rdata  in  8  memory registered read data (1-cycle latency).
REQ-017 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-018 SHALL have port rx_overrun  out  1  one-cycle pulse, byte dropped.

Function
REQ-019 Frame SHALL be: command, addr high (bits [5:0] used), addr low, then one data byte for writes only.
REQ-020 States SHALL be IDLE, ADDR_H, ADDR_L, DATA, MEM_WR, MEM_RD, RD_CAP, TX_REQ, TX_WAIT.
REQ-021 IDLE: rx_valid with CMD_WR or CMD_RD -> ADDR_H, opcode latched; any other byte -> TX_REQ with NAK.
REQ-022 ADDR_H: byte with bits [7:6] nonzero -> TX_REQ with NAK; else bits [5:0] latched as mem_addr[13:8] -> ADDR_L.
REQ-023 ADDR_L: byte latched as mem_addr[7:0]; write -> DATA, read -> MEM_RD.
REQ-024 DATA: byte latched into mem_wdata -> MEM_WR.
REQ-025 MEM_WR: mem_write=1 for exactly this one cycle -> TX_REQ with ACK.
REQ-026 MEM_RD: mem_write=0, address presented -> RD_CAP; RD_CAP captures mem_rdata as tx_data -> TX_REQ.
REQ-027 Read latency SHALL be 2 cycles from addr-low strobe to data capture.
REQ-028 mem_addr and mem_wdata SHALL hold stable from latch until the next frame latches new values.
REQ-029 TX_REQ: tx_start=1 for one cycle only when tx_busy=0, else wait; then TX_WAIT.
REQ-030 TX_WAIT: returns to IDLE when tx_busy=0 observed one cycle after tx_start or later.
REQ-031 tx_data SHALL hold stable from TX_REQ entry until IDLE return.
REQ-032 rx_valid in MEM_WR, MEM_RD, RD_CAP, TX_REQ or TX_WAIT SHALL drop the byte and pulse rx_overrun.
REQ-033 Timeout counter SHALL clear on each accepted byte; reaching TIMEOUT in ADDR_H, ADDR_L or DATA -> IDLE, no memory access, no response.
REQ-034 mem_write SHALL never be asserted outside MEM_WR.

Reset
REQ-035 On rst: state IDLE, tx_start=0, tx_data=8'h00, mem_addr=0, mem_write=0, mem_wdata=8'h00, busy=0, rx_overrun=0, timeout counter=0.
REQ-036 rst asserted mid-frame SHALL abort with no memory write and no transmit after release.

Structure
REQ-037 State encoding, command/response byte defaults and frame constants SHALL reside in shared package rs232_mem_pkg.
REQ-038 Inter-byte timer SHALL be sub-module rs232_mem_timeout (clear, enable, expired).
REQ-039 Memory macro SHALL be instantiated at top level, not inside this block.

Verification
REQ-040 57,00,10,A5 with tx_busy=0 -> mem_write one cycle, addr 14'h0010, wdata A5; tx_data 4B.
REQ-041 52,00,10 after REQ-040 -> mem_write stays 0, 2 cycles later tx_data A5, tx_start one pulse.
REQ-042 Byte 41 in IDLE -> tx_data 3F; 52,C0,00 -> 3F after addr high, no memory access.
REQ-043 57,3F followed by silence TIMEOUT cycles -> IDLE, busy=0, no tx_start, no write.
REQ-044 tx_busy=1 during response and extra rx_valid -> tx_start delayed until tx_busy=0; rx_overrun pulses once.
REQ-045 rst asserted in DATA state -> all outputs at reset values; no write to addr after release.
